// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seg_display_pkg;

  localparam int MAX_DIGITS = 8;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  // Active-low one-hot anode pattern: every bit high except bit pos
  function automatic logic [MAX_DIGITS-1:0] onehot_n(input logic [2:0] pos);
    return ~(MAX_DIGITS'(1) << pos);
  endfunction

endpackage

// File: rtl/seg_decode_hex.sv
// Combinational nibble to active-low 7-segment decoder; hex letters optional.
module seg_decode_hex
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] seg
);

  // Map the nibble to its segment pattern; 10-15 go dark unless hex is enabled
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = hex_en ? SEG_A : SEG_BLANK;
      4'd11: seg = hex_en ? SEG_B : SEG_BLANK;
      4'd12: seg = hex_en ? SEG_C : SEG_BLANK;
      4'd13: seg = hex_en ? SEG_D : SEG_BLANK;
      4'd14: seg = hex_en ? SEG_E : SEG_BLANK;
      4'd15: seg = hex_en ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with
// shadow-latched data, blanking, blinking and leading-zero suppression.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 250,
  parameter int HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic [NUM_DIGITS-1:0]   blink_q;
  logic                    lz_q;

  logic [SCAN_W-1:0]       scan_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLINK_W-1:0]      blink_cnt;
  logic                    blink_phase;

  logic                    slot_end;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic [3:0]              cur_nibble;
  logic                    cur_dark;
  logic [6:0]              dec_seg;

  assign slot_end = (scan_cnt == SCAN_LAST);

  // Shadow registers: the display only ever reads these, never the live inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
      blank_q <= '0;
      blink_q <= '0;
      lz_q    <= 1'b0;
    end else if (load) begin
      value_q <= value;
      blank_q <= blank_mask;
      blink_q <= blink_mask;
      lz_q    <= lz_en;
    end
  end

  // Slot timer and digit index; the index advances on the guard edge of each slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink timebase counts slots and flips the phase every BLINK_DIV slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (slot_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (value_q[4*k +: 4] == 4'd0);
      lz_mask[k] = lz_q & upper_zero;
    end
  end

  // Select the current digit's nibble and work out whether it must stay dark
  always_comb begin
    cur_nibble = 4'd0;
    cur_dark   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nibble = value_q[4*k +: 4];
        cur_dark   = blank_q[k] | lz_mask[k] | (blink_q[k] & blink_phase);
      end
    end
  end

  seg_decode_hex u_decode (
    .nibble (cur_nibble),
    .hex_en (HEX_MODE != 0),
    .seg    (dec_seg)
  );

  // Registered pin drive; the last cycle of every slot is a dark guard cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg       <= SEG_BLANK;
      digit_sel <= '1;
    end else if (slot_end) begin
      seg       <= SEG_BLANK;
      digit_sel <= '1;
    end else begin
      seg       <= cur_dark ? SEG_BLANK : dec_seg;
      digit_sel <= NUM_DIGITS'(onehot_n(3'(idx)));
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench: directed scenarios plus random traffic against a
// slot/time based reference model; two DUTs cover hex and BCD decode.
module tb_seg_display_mux;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic [6:0]  seg_hex, seg_bcd;
  logic [3:0]  sel_hex, sel_bcd;

  int check_count = 0;
  int pass_count  = 0;

  // Model state: edges since reset release and the model's own shadow copy
  int          edge_n = 0;
  logic [15:0] m_value = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  m_blink = '0;
  logic        m_lz    = 1'b0;

  logic [6:0]  hex_tab [16];
  logic [6:0]  bcd_tab [16];

  seg_display_mux #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV),
                    .BLINK_DIV(BLINK_DIV), .HEX_MODE(1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg(seg_hex), .digit_sel(sel_hex)
  );

  seg_display_mux #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV),
                    .BLINK_DIV(BLINK_DIV), .HEX_MODE(0)) dut_bcd (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
    .seg(seg_bcd), .digit_sel(sel_bcd)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edge_n, got, exp);
  endtask

  task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] v,
                               input logic [3:0] bm, input logic [3:0] blm, input logic lz);
    rst_n      = r;
    load       = ld;
    value      = v;
    blank_mask = bm;
    blink_mask = blm;
    lz_en      = lz;
  endtask

  // Advance one clock, predict outputs from slot arithmetic, then compare
  task automatic stepCycle();
    int         pos, slot, d;
    logic       ph, dark;
    logic [3:0] nib;
    logic [6:0] e_hex, e_bcd;
    logic [3:0] e_sel;
    @(posedge clk);
    e_hex = 7'h7F;
    e_bcd = 7'h7F;
    e_sel = 4'hF;
    if (!rst_n) begin
      edge_n  = 0;
      m_value = '0;
      m_blank = '0;
      m_blink = '0;
      m_lz    = 1'b0;
    end else begin
      edge_n++;
      pos  = (edge_n - 1) % SCAN_DIV;
      slot = (edge_n - 1) / SCAN_DIV;
      d    = slot % NUM_DIGITS;
      ph   = ((slot / BLINK_DIV) % 2) == 1;
      if (pos != SCAN_DIV - 1) begin
        nib  = 4'((m_value >> (4 * d)) & 16'hF);
        dark = m_blank[d] || (m_blink[d] && ph) ||
               (m_lz && d != 0 && (m_value >> (4 * d)) == 16'd0);
        e_sel    = 4'hF;
        e_sel[d] = 1'b0;
        e_hex    = dark ? 7'h7F : hex_tab[nib];
        e_bcd    = dark ? 7'h7F : bcd_tab[nib];
      end
      if (load) begin
        m_value = value;
        m_blank = blank_mask;
        m_blink = blink_mask;
        m_lz    = lz_en;
      end
    end
    #1;
    checkOutput("seg_hex", 32'(seg_hex), 32'(e_hex));
    checkOutput("seg_bcd", 32'(seg_bcd), 32'(e_bcd));
    checkOutput("sel_hex", 32'(sel_hex), 32'(e_sel));
    checkOutput("sel_bcd", 32'(sel_bcd), 32'(e_sel));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    bcd_tab = hex_tab;
    for (int i = 10; i < 16; i++) bcd_tab[i] = 7'b1111111;

    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(3);

    // Scan order with a plain value
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);
    runCycles(21);

    // Reset in the middle of a slot, then resume
    applyStimulus(1'b0, 1'b0, 16'h1234, 4'h0, 4'h0, 1'b0);
    runCycles(3);
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(8);

    // Hex letter on digit 0
    applyStimulus(1'b1, 1'b1, 16'hF0EA, 4'h0, 4'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(18);

    // Leading-zero suppression, including an all-zero value
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'h0, 4'h0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(17);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h1111, 4'h0, 4'h0, 1'b0);
    runCycles(17);

    // Blink on digit 0, forced blank on digit 3
    applyStimulus(1'b1, 1'b1, 16'h8888, 4'h8, 4'h1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(48);

    // Load landing in digit 0's second lit cycle
    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(2);
    applyStimulus(1'b1, 1'b1, 16'h0009, 4'h0, 4'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0);
    runCycles(6);

    // Load held high: transparent capture every cycle
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 16'($urandom), 4'h0, 4'h0, 1'b0);
      stepCycle();
    end

    // Random traffic with occasional loads and resets
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                    4'($urandom),
                    1'($urandom));
      stepCycle();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
